escaneo_teclado: RTL and testbench



---
 rtl/teclado_pkg.sv | 32 +++
 rtl/escaneo_teclado_divisor_tick.sv | 22 ++
 rtl/escaneo_teclado.sv | 128 ++++++++++++
 tb/tb_escaneo_teclado.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/teclado_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package teclado_pkg;

  typedef enum logic [1:0] {BARRIDO, CONFIRMAR, PRESIONADA, LIBERAR} estado_t;

  localparam logic [3:0] FILA_INICIAL = 4'b1110;
  localparam int ANCHO_CODIGO = 4;

  function automatic logic [1:0] indice_fila(input logic [3:0] filas);
    logic [1:0] idx;
    idx = 2'd0;
    case (filas)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Fixed priority: the lowest-index low column wins.
  function automatic logic [1:0] columna_baja(input logic [3:0] cols);
    logic [1:0] idx;
    idx = 2'd0;
    if (!cols[0])      idx = 2'd0;
    else if (!cols[1]) idx = 2'd1;
    else if (!cols[2]) idx = 2'd2;
    else if (!cols[3]) idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/escaneo_teclado_divisor_tick.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
module divisor_tick #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int W = $clog2(DIV);

  logic [W-1:0] cuenta;

  assign tick = (cuenta == W'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cuenta <= '0;
    else if (tick) cuenta <= '0;
    else           cuenta <= cuenta + 1'b1;
  end

endmodule

// File: rtl/escaneo_teclado.sv
// Row-scanning 4x4 keypad reader with press/release debounce and a one-cycle
// strobe carrying the {row, col} position code.
module escaneo_teclado
  import teclado_pkg::*;
#(
  parameter int DIV_ESCANEO = 50000,
  parameter int N_ESTABLE   = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0]              columnas_n,
  output logic [3:0]              filas_n,
  output logic [ANCHO_CODIGO-1:0] codigo_tecla,
  output logic                    tecla_valida,
  output logic                    tecla_presionada
);

  localparam int CW = $clog2(N_ESTABLE + 1);

  logic                    tick;
  logic [3:0]              sinc1, sinc2;
  estado_t                 estado, estado_sig;
  logic [CW-1:0]           cuenta, cuenta_sig;
  logic [1:0]              col, col_sig;
  logic [3:0]              filas_sig;
  logic [ANCHO_CODIGO-1:0] codigo_sig;
  logic                    valida_sig;
  logic                    hay_golpe;
  logic [1:0]              col_golpe;
  logic [3:0]              filas_rot;
  logic                    ultimo;

  divisor_tick #(.DIV(DIV_ESCANEO)) u_divisor (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sinc1 <= 4'hF;
      sinc2 <= 4'hF;
    end else begin
      sinc1 <= columnas_n;
      sinc2 <= sinc1;
    end
  end

  assign hay_golpe = ~&sinc2;
  assign col_golpe = columna_baja(sinc2);
  assign filas_rot = {filas_n[2:0], filas_n[3]};
  // The stability count is compared before incrementing, so it never exceeds N_ESTABLE.
  assign ultimo    = (cuenta == CW'(N_ESTABLE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado       <= BARRIDO;
      cuenta       <= '0;
      col          <= 2'd0;
      filas_n      <= FILA_INICIAL;
      codigo_tecla <= '0;
      tecla_valida <= 1'b0;
    end else begin
      estado       <= estado_sig;
      cuenta       <= cuenta_sig;
      col          <= col_sig;
      filas_n      <= filas_sig;
      codigo_tecla <= codigo_sig;
      tecla_valida <= valida_sig;
    end
  end

  always_comb begin
    estado_sig = estado;
    cuenta_sig = cuenta;
    col_sig    = col;
    filas_sig  = filas_n;
    codigo_sig = codigo_tecla;
    valida_sig = 1'b0;
    if (tick) begin
      case (estado)
        BARRIDO: begin
          if (hay_golpe) begin
            col_sig    = col_golpe;
            cuenta_sig = CW'(1);
            estado_sig = CONFIRMAR;
          end else begin
            filas_sig = filas_rot;
          end
        end
        CONFIRMAR: begin
          if (hay_golpe && (col_golpe == col)) begin
            cuenta_sig = cuenta + 1'b1;
            if (ultimo) begin
              estado_sig = PRESIONADA;
              codigo_sig = {indice_fila(filas_n), col};
              valida_sig = 1'b1;
            end
          end else begin
            estado_sig = BARRIDO;
            filas_sig  = filas_rot;
          end
        end
        PRESIONADA: begin
          if (!hay_golpe) begin
            cuenta_sig = CW'(1);
            estado_sig = LIBERAR;
          end
        end
        LIBERAR: begin
          if (hay_golpe) begin
            estado_sig = PRESIONADA;
          end else begin
            cuenta_sig = cuenta + 1'b1;
            if (ultimo) begin
              estado_sig = BARRIDO;
              filas_sig  = filas_rot;
            end
          end
        end
        default: estado_sig = BARRIDO;
      endcase
    end
  end

  assign tecla_presionada = (estado == PRESIONADA) || (estado == LIBERAR);

endmodule

// File: tb/tb_escaneo_teclado.sv
// Bench for escaneo_teclado: keypad model, cycle-level reference model and
// directed press/bounce/reset scenarios.
module tb_escaneo_teclado;

  localparam int DIV = 8;
  localparam int NE  = 3;
  localparam int TICK = DIV;

  localparam int M_SCAN    = 0;
  localparam int M_CONFIRM = 1;
  localparam int M_HELD    = 2;
  localparam int M_RELEASE = 3;

  logic       clk;
  logic       rst_n;
  logic [3:0] columnas_n;
  logic [3:0] filas_n;
  logic [3:0] codigo_tecla;
  logic       tecla_valida;
  logic       tecla_presionada;

  logic [15:0] keys;
  int checks;
  int failures;
  int strobes;
  logic [3:0] last_code;

  escaneo_teclado #(.DIV_ESCANEO(DIV), .N_ESTABLE(NE)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .columnas_n       (columnas_n),
    .filas_n          (filas_n),
    .codigo_tecla     (codigo_tecla),
    .tecla_valida     (tecla_valida),
    .tecla_presionada (tecla_presionada)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A held key shorts its row line to its column line.
  always_comb begin
    columnas_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !filas_n[r]) columnas_n[c] = 1'b0;
  end

  int         m_cycles;
  logic [3:0] m_s1, m_s2;
  int         m_row, m_mode, m_streak, m_cand;
  logic [3:0] m_code;
  logic       m_strobe;

  always @(posedge clk or negedge rst_n) begin : model
    int hit_col;
    int nrow, nmode, nstreak, ncand;
    logic [3:0] ncode;
    logic nstrobe;
    if (!rst_n) begin
      m_cycles <= 0;
      m_s1     <= 4'hF;
      m_s2     <= 4'hF;
      m_row    <= 0;
      m_mode   <= M_SCAN;
      m_streak <= 0;
      m_cand   <= 0;
      m_code   <= 4'h0;
      m_strobe <= 1'b0;
    end else begin
      hit_col = -1;
      for (int c = 3; c >= 0; c--) if (!m_s2[c]) hit_col = c;
      nrow = m_row; nmode = m_mode; nstreak = m_streak; ncand = m_cand;
      ncode = m_code; nstrobe = 1'b0;
      if ((m_cycles % DIV) == DIV - 1) begin
        case (m_mode)
          M_SCAN:
            if (hit_col >= 0) begin ncand = hit_col; nstreak = 1; nmode = M_CONFIRM; end
            else nrow = (m_row + 1) % 4;
          M_CONFIRM:
            if (hit_col == m_cand) begin
              nstreak = m_streak + 1;
              if (nstreak == NE) begin
                nmode = M_HELD; nstrobe = 1'b1; ncode = 4'(m_row * 4 + m_cand);
              end
            end else begin
              nmode = M_SCAN; nrow = (m_row + 1) % 4;
            end
          M_HELD:
            if (hit_col < 0) begin nstreak = 1; nmode = M_RELEASE; end
          default:
            if (hit_col >= 0) nmode = M_HELD;
            else begin
              nstreak = m_streak + 1;
              if (nstreak == NE) begin nmode = M_SCAN; nrow = (m_row + 1) % 4; end
            end
        endcase
      end
      m_cycles <= m_cycles + 1;
      m_s1     <= columnas_n;
      m_s2     <= m_s1;
      m_row    <= nrow;
      m_mode   <= nmode;
      m_streak <= nstreak;
      m_cand   <= ncand;
      m_code   <= ncode;
      m_strobe <= nstrobe;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("cyc_filas_n", int'(filas_n), int'(4'hF & ~(4'h1 << m_row)));
    checkOutput("cyc_codigo", int'(codigo_tecla), int'(m_code));
    checkOutput("cyc_valida", int'(tecla_valida), int'(m_strobe));
    checkOutput("cyc_presionada", int'(tecla_presionada), int'(m_mode >= M_HELD));
    if (tecla_valida === 1'b1) begin
      strobes++;
      last_code = codigo_tecla;
    end
  end

  task automatic applyStimulus(input int key, input logic val, input int cycles);
    keys[key] = val;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic waitRowZero();
    logic [3:0] prev;
    bit found;
    found = 1'b0;
    prev = filas_n;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (prev == 4'b0111 && filas_n == 4'b1110) found = 1'b1;
      prev = filas_n;
    end
    if (!found) checkOutput("row0_wait_timeout", 0, 1);
    #2;
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stim
    int base;
    checks = 0; failures = 0; strobes = 0; last_code = 4'h0;
    keys = 16'h0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_filas_n", int'(filas_n), 'he);
    checkOutput("reset_codigo", int'(codigo_tecla), 0);
    checkOutput("reset_presionada", int'(tecla_presionada), 0);
    #2 rst_n = 1'b1;

    // Idle scan: rows step every DIV cycles.
    repeat (4) @(negedge clk);
    checkOutput("idle_row0", int'(filas_n), 'he);
    repeat (TICK) @(negedge clk);
    checkOutput("idle_row1", int'(filas_n), 'hd);
    repeat (TICK) @(negedge clk);
    checkOutput("idle_row2", int'(filas_n), 'hb);
    repeat (TICK) @(negedge clk);
    checkOutput("idle_row3", int'(filas_n), 'h7);
    repeat (TICK) @(negedge clk);
    checkOutput("idle_wrap", int'(filas_n), 'he);
    checkOutput("idle_strobes", strobes, 0);

    base = strobes;
    applyStimulus(5, 1'b1, 20 * TICK);
    checkOutput("press5_held", int'(tecla_presionada), 1);
    applyStimulus(5, 1'b0, 6 * TICK);
    checkOutput("press5_strobes", strobes - base, 1);
    checkOutput("press5_code", int'(last_code), 'h5);
    checkOutput("press5_released", int'(tecla_presionada), 0);

    base = strobes;
    waitRowZero();
    applyStimulus(3, 1'b1, 2 * TICK);
    applyStimulus(3, 1'b0, 4 * TICK);
    checkOutput("bounce_strobes", strobes - base, 0);
    checkOutput("bounce_code_kept", int'(codigo_tecla), 'h5);
    checkOutput("bounce_presionada", int'(tecla_presionada), 0);

    base = strobes;
    applyStimulus(5, 1'b1, 20 * TICK);
    applyStimulus(5, 1'b0, TICK);
    applyStimulus(5, 1'b1, 5 * TICK);
    checkOutput("relbounce_held", int'(tecla_presionada), 1);
    applyStimulus(5, 1'b0, 6 * TICK);
    checkOutput("relbounce_strobes", strobes - base, 1);
    base = strobes;
    applyStimulus(15, 1'b1, 20 * TICK);
    applyStimulus(15, 1'b0, 6 * TICK);
    checkOutput("press15_strobes", strobes - base, 1);
    checkOutput("press15_code", int'(last_code), 'hf);

    base = strobes;
    keys[8] = 1'b1;
    applyStimulus(10, 1'b1, 20 * TICK);
    keys[8] = 1'b0;
    applyStimulus(10, 1'b0, 6 * TICK);
    checkOutput("twokeys_strobes", strobes - base, 1);
    checkOutput("twokeys_code", int'(last_code), 'h8);

    // Reset while a press is being confirmed.
    base = strobes;
    waitRowZero();
    applyStimulus(0, 1'b1, 10);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_filas_n", int'(filas_n), 'he);
    checkOutput("midreset_codigo", int'(codigo_tecla), 0);
    checkOutput("midreset_valida", int'(tecla_valida), 0);
    checkOutput("midreset_presionada", int'(tecla_presionada), 0);
    applyStimulus(0, 1'b0, 3);
    #2 rst_n = 1'b1;
    repeat (6 * TICK) @(negedge clk);
    checkOutput("midreset_strobes", strobes - base, 0);
    applyStimulus(0, 1'b1, 20 * TICK);
    applyStimulus(0, 1'b0, 6 * TICK);
    checkOutput("after_reset_strobes", strobes - base, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
